// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART transmit path.
// Sequencer state encoding and the default baud divisor.
package uart_pkg;

    localparam int CLKS_115200_50MHZ = 434;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] LOAD   = 3'd2;
    localparam logic [2:0] START  = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] PARITY = 3'd5;
    localparam logic [2:0] STOP   = 3'd6;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: serial bit-period counter.
// bit_end marks the last clk of a bit, bit_pre_end the one before it.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_115200_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic bit_end,
    output logic bit_pre_end
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    // Count 0..CLKS_PER_BIT-1 while running, wrap, hold zero when cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign bit_end     = run && (cnt == LAST);
    assign bit_pre_end = run && (cnt == PRE);

endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: pops bytes from the TX FIFO and serialises them onto tx.
// Define UART_TX_PARITY_EN to add an even parity bit after the data bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_115200_50MHZ,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_BITS-1:0] fifo_rd_data,
    output logic                 fifo_rd_en,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic [2:0]           state;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_nxt;
    logic                 run;
    logic                 bit_end;
    logic                 bit_pre_end;

`ifdef UART_TX_PARITY_EN
    logic parity_reg;

    // Even parity of the byte captured in LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_reg <= 1'b0;
        end else if (state == LOAD) begin
            parity_reg <= ^fifo_rd_data;
        end
    end

    assign run = (state == START) || (state == DATA) ||
                 (state == PARITY) || (state == STOP);
`else
    assign run = (state == START) || (state == DATA) ||
                 (state == STOP);
`endif

    assign shift_nxt = shift_reg >> 1;
    assign busy      = (state != IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk         (clk),
        .rst         (rst),
        .clr         (~run),
        .run         (run),
        .bit_end     (bit_end),
        .bit_pre_end (bit_pre_end)
    );

    // Frame sequencer; tx_done is set one clk early so it lands on the
    // final stop-bit cycle as a registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tx         <= 1'b1;
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
        end else begin
            tx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (enable && !fifo_empty) begin
                        fifo_rd_en <= 1'b1;
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    fifo_rd_en <= 1'b0;
                    state      <= LOAD;
                end
                LOAD: begin
                    shift_reg <= fifo_rd_data;
                    bit_cnt   <= '0;
                    tx        <= 1'b0;
                    state     <= START;
                end
                START: begin
                    if (bit_end) begin
                        tx    <= shift_reg[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx      <= parity_reg;
                            state   <= PARITY;
`else
                            tx      <= 1'b1;
                            state   <= STOP;
`endif
                        end else begin
                            shift_reg <= shift_nxt;
                            tx        <= shift_nxt[0];
                            bit_cnt   <= bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        tx    <= 1'b1;
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (bit_pre_end && bit_cnt == STOP_LAST) begin
                        tx_done <= 1'b1;
                    end
                    if (bit_end) begin
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    tx         <= 1'b1;
                    fifo_rd_en <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl.
// A second instance with two stop bits shares the FIFO model.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       enable2 = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       fifo_rd_en, fifo_rd_en2;
    logic       tx, tx2, busy, busy2, tx_done, tx_done2;
    logic       sel2 = 1'b0;
    logic       mon_tx, mon_done, mon_busy;

    int nvec = 0;
    int nerr = 0;
    int rd_cnt = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         gap_q[$];
    int         gapb_q[$];

    always #5 clk = ~clk;

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (1)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    uart_tx_ctrl #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .STOP_BITS    (2)
    ) u_dut2 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable2),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en2),
        .tx           (tx2),
        .busy         (busy2),
        .tx_done      (tx_done2)
    );

    // FIFO model: registered read data, flag updated between edges.
    always @(posedge clk) begin
        if (fifo_rd_en || fifo_rd_en2) begin
            rd_cnt = rd_cnt + 1;
            if (fq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL fifo_underflow: pop with fifo empty, required no pop");
            end else begin
                fifo_rd_data <= fq.pop_front();
            end
        end
    end

    always @(negedge clk) fifo_empty <= (fq.size() == 0);

    always_comb begin
        mon_tx   = sel2 ? tx2 : tx;
        mon_done = sel2 ? tx_done2 : tx_done;
        mon_busy = sel2 ? busy2 : busy;
    end

    // Monitor: decodes each frame on the selected line and checks it
    // cycle by cycle against the next expected byte.
    initial begin : monitor
        logic        prev;
        logic        have, ab, bad, b_tx, b_done, b_busy;
        logic [7:0]  e, got;
        logic [15:0] lv;
        int          gap, gapb, nb, stopn, bad_k;
        prev = 1'b1;
        gap  = 0;
        gapb = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
                continue;
            end
            if (prev && !mon_tx) begin
                gap_q.push_back(gap);
                gapb_q.push_back(gapb);
                gap   = 0;
                gapb  = 0;
                stopn = sel2 ? 2 : 1;
                nb    = 1 + 8 + PB + stopn;
                have  = (exp_q.size() != 0);
                e     = have ? exp_q.pop_front() : 8'h00;
                lv    = '1;
                lv[0] = 1'b0;
                for (int i = 0; i < 8; i++) lv[1+i] = e[i];
                if (PB == 1) lv[9] = ^e;
                ab = 0; bad = 0; bad_k = -1; got = 8'h00;
                b_tx = 0; b_done = 0; b_busy = 0;
                for (int k = 0; k < nb * CPB; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst) begin
                        ab = 1;
                        break;
                    end
                    if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= 8)
                        got[k/CPB-1] = mon_tx;
                    if (!bad && (mon_tx !== lv[k/CPB] ||
                                 mon_done !== (k == nb * CPB - 1) ||
                                 mon_busy !== 1'b1)) begin
                        bad = 1; bad_k = k;
                        b_tx = mon_tx; b_done = mon_done; b_busy = mon_busy;
                    end
                end
                prev = ab ? 1'b1 : mon_tx;
                if (!ab) begin
                    nvec++;
                    if (!have) begin
                        nerr++;
                        $display("FAIL frame_unexpected: got frame data 0x%02h, required no frame", got);
                    end else if (bad) begin
                        nerr++;
                        $display("FAIL frame_0x%02h: cycle %0d tx=%b done=%b busy=%b, required tx=%b done=%b busy=1",
                                 e, bad_k, b_tx, b_done, b_busy, lv[bad_k/CPB], (bad_k == nb * CPB - 1));
                    end
                end
            end else begin
                gap++;
                if (!mon_busy) gapb++;
                if (mon_done) begin
                    nvec++;
                    nerr++;
                    $display("FAIL spurious_done: tx_done=1 outside a frame, required 0");
                end
                prev = mon_tx;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic wait_done(input string nm, input int lim);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(posedge clk);
            #1;
            if (mon_done) seen = 1'b1;
        end
        chk(nm, {31'd0, seen}, 32'd1);
    endtask

    task automatic send(input logic [7:0] b);
        fq.push_back(b);
        exp_q.push_back(b);
    endtask

    initial begin : stim
        logic flag;
        int   r0;
        rst = 1'b1;
        tick(3);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("rst_done", {31'd0, tx_done}, 32'd0);
        rst = 1'b0;
        tick(2);

        // Reset in the middle of a 0x00 frame.
        enable = 1'b1;
        send(8'h00);
        tick(20);
        chk("pre_rst_tx_low", {31'd0, tx}, 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        tick(2);
        rst = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (tx_done || !tx || busy || fifo_rd_en) flag = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, flag}, 32'd0);

        // Single byte 0xA5: latency and tx_done position.
        send(8'hA5);
        tick(1);
        chk("lat_e0_rd_en", {31'd0, fifo_rd_en}, 32'd1);
        chk("lat_e0_tx", {31'd0, tx}, 32'd1);
        tick(1);
        chk("lat_e1_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        chk("lat_e1_tx", {31'd0, tx}, 32'd1);
        tick(1);
        chk("lat_e2_tx", {31'd0, tx}, 32'd0);
        tick(39 + PB * CPB);
        chk("done_cycle", {31'd0, tx_done}, 32'd1);
        tick(1);
        chk("done_pulse_end", {31'd0, tx_done}, 32'd0);
        chk("idle_after", {31'd0, busy}, 32'd0);

        // enable low with data waiting, then back-to-back frames.
        enable = 1'b0;
        send(8'h00);
        send(8'hFF);
        send(8'h55);
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (fifo_rd_en || !tx || busy) flag = 1'b1;
        end
        chk("en0_hold", {31'd0, flag}, 32'd0);
        gap_q.delete();
        gapb_q.delete();
        r0 = rd_cnt;
        enable = 1'b1;
        wait_done("b2b_done0", 80);
        wait_done("b2b_done1", 80);
        wait_done("b2b_done2", 80);
        tick(2);
        chk("b2b_rd_pulses", rd_cnt - r0, 32'd3);
        chk("b2b_frames", gap_q.size(), 32'd3);
        chk("b2b_gap1", gap_q[1], 32'd3);
        chk("b2b_gap2", gap_q[2], 32'd3);
        chk("b2b_busy_low1", gapb_q[1], 32'd1);
        chk("b2b_busy_low2", gapb_q[2], 32'd1);

        // Drop enable mid-frame.
        send(8'h5A);
        fq.push_back(8'h3C);
        tick(12);
        enable = 1'b0;
        wait_done("drop_done", 80);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (fifo_rd_en || !tx || busy) flag = 1'b1;
        end
        chk("drop_no_fetch", {31'd0, flag}, 32'd0);
        chk("drop_fifo_left", fq.size(), 32'd1);
        exp_q.push_back(8'h3C);
        enable = 1'b1;
        wait_done("resume_done", 80);
        tick(2);

        // Parity patterns (odd and even weight).
        send(8'h07);
        send(8'h03);
        wait_done("par07_done", 80);
        wait_done("par03_done", 80);
        tick(2);

        // Two stop bits on the second instance.
        enable = 1'b0;
        tick(2);
        sel2 = 1'b1;
        enable2 = 1'b1;
        send(8'h81);
        wait_done("stop2_done", 90);
        tick(1);
        chk("stop2_idle", {31'd0, busy2}, 32'd0);
        enable2 = 1'b0;
        tick(3);

        chk("exp_q_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
